l_class_oc_fifop: RTL and testbench

- Parametrised successor to the single-entry guarded-method FIFO; this is the first generation with real storage.
- Circular-buffer FIFO of DEPTH entries of WIDTH bits behind the same guarded-method interfaces: in.enq, out.deq, out.first.
- Adds an occupancy count, an almost-full flag, a synchronous clear method and an optional pipelined mode (enq while full, paired with a same-cycle deq).
- Sits between producer/consumer modules in generated designs (e.g. echo request/indication paths).

---
 rtl/l_class_oc_fifop_pkg.sv | 21 ++
 rtl/l_class_oc_fifop_if.sv | 28 ++
 rtl/l_class_oc_fifop_storage.sv | 24 ++
 rtl/l_class_oc_fifop.sv | 96 +++++++++
 tb/tb_l_class_oc_fifop.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/l_class_oc_fifop_pkg.sv
// Shared sizing helpers and parameter legality checks for the guarded-method FIFO family.
package l_fifo_pkg;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  // Occupancy needs one extra bit so that DEPTH itself is representable.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit afull_ok(input int depth, input int afull_level);
    return (afull_level >= 1) && (afull_level <= depth);
  endfunction

endpackage

// File: rtl/l_class_oc_fifop_if.sv
// Guarded-method bundle: enq/deq/first/clear plus occupancy status.
// Handshake: a method fires on a rising edge only when its __ENA and __RDY are both high;
// __ENA without __RDY has no effect. in_clear__ENA is always ready.
interface l_class_oc_fifop_if #(
  parameter int WIDTH = 32,
  parameter int CW    = 3
);
  logic             in_enq__ENA;
  logic [WIDTH-1:0] in_enq_v;
  logic             in_enq__RDY;
  logic             out_deq__ENA;
  logic             out_deq__RDY;
  logic [WIDTH-1:0] out_first;
  logic             out_first__RDY;
  logic             in_clear__ENA;
  logic [CW-1:0]    out_count;
  logic             out_afull;

  modport master (
    output in_enq__ENA, in_enq_v, out_deq__ENA, in_clear__ENA,
    input  in_enq__RDY, out_deq__RDY, out_first, out_first__RDY, out_count, out_afull
  );

  modport slave (
    input  in_enq__ENA, in_enq_v, out_deq__ENA, in_clear__ENA,
    output in_enq__RDY, out_deq__RDY, out_first, out_first__RDY, out_count, out_afull
  );
endinterface

// File: rtl/l_class_oc_fifop_storage.sv
// DEPTH x WIDTH register array: one synchronous write port, one combinational read port.
module l_fifo_storage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Contents are deliberately not reset; validity is tracked by the owner's count.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/l_class_oc_fifop.sv
// Circular-buffer FIFO behind guarded enq/deq/first methods, with count, almost-full,
// synchronous clear and an optional pipelined enq-while-full mode.
module l_class_oc_fifop
  import l_fifo_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 4,
  parameter bit PIPELINED   = 1'b0,
  parameter int AFULL_LEVEL = DEPTH - 1
) (
  input  logic                CLK,
  input  logic                RST,
  l_class_oc_fifop_if.slave   bus
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = count_width(DEPTH);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LEVEL);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("l_class_oc_fifop: DEPTH must be a power of two >= 2");
  end
  if (!afull_ok(DEPTH, AFULL_LEVEL)) begin : g_bad_afull
    $error("l_class_oc_fifop: AFULL_LEVEL must lie in 1..DEPTH");
  end

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic not_empty, not_full, enq_rdy, enq_fire, deq_fire, clear;
  logic [WIDTH-1:0] head_data;

  assign not_empty = (count_q != '0);
  assign not_full  = (count_q != FULL_CNT);

  // In pipelined mode a full FIFO can still accept when the consumer dequeues this
  // cycle; deq is always ready when full, so ENA alone is sufficient.
  assign enq_rdy  = not_full | (PIPELINED & bus.out_deq__ENA);
  assign enq_fire = bus.in_enq__ENA & enq_rdy;
  assign deq_fire = bus.out_deq__ENA & not_empty;
  assign clear    = bus.in_clear__ENA;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (enq_fire) wr_ptr_d = wr_ptr_q + PW'(1);
    if (deq_fire) rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({enq_fire, deq_fire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Clear wins over any same-cycle method fire.
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  l_fifo_storage #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_storage (
    .clk_i   (CLK),
    .we_i    (enq_fire & ~clear),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.in_enq_v),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_data)
  );

  assign bus.in_enq__RDY    = enq_rdy;
  assign bus.out_deq__RDY   = not_empty;
  assign bus.out_first__RDY = not_empty;
  assign bus.out_first      = head_data;
  assign bus.out_count      = count_q;
  assign bus.out_afull      = (count_q >= AFULL_CNT);

endmodule

// File: tb/tb_l_class_oc_fifop.sv
// Bench for l_class_oc_fifop: DEPTH=4 FIFOs, one non-pipelined (table + corner sequences)
// and one pipelined (enq-while-full sequence).
module tb_l_class_oc_fifop;

  localparam int W  = 8;
  localparam int CW = 3;

  logic clk;
  logic rst;

  l_class_oc_fifop_if #(.WIDTH(W), .CW(CW)) if0 ();
  l_class_oc_fifop_if #(.WIDTH(W), .CW(CW)) if1 ();

  l_class_oc_fifop #(.WIDTH(W), .DEPTH(4), .PIPELINED(1'b0), .AFULL_LEVEL(3)) dut0 (
    .CLK (clk),
    .RST (rst),
    .bus (if0)
  );

  l_class_oc_fifop #(.WIDTH(W), .DEPTH(4), .PIPELINED(1'b1), .AFULL_LEVEL(3)) dut1 (
    .CLK (clk),
    .RST (rst),
    .bus (if1)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp  = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic         enq;
    logic [W-1:0] d;
    logic         deq;
    logic         clr;
    logic [CW-1:0] cnt;
    logic         erdy;
    logic         drdy;
    logic         af;
    logic         chkf;
    logic [W-1:0] first;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic enq, input logic [W-1:0] d, input logic deq,
                              input logic clr, input logic [CW-1:0] cnt, input logic erdy,
                              input logic drdy, input logic af, input logic chkf,
                              input logic [W-1:0] first);
    vec_t v;
    v.enq = enq; v.d = d; v.deq = deq; v.clr = clr; v.cnt = cnt;
    v.erdy = erdy; v.drdy = drdy; v.af = af; v.chkf = chkf; v.first = first;
    return v;
  endfunction

  // Scoreboard compare
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drivers
  task automatic drive0(input logic enq, input logic [W-1:0] d, input logic deq, input logic clr);
    if0.in_enq__ENA = enq; if0.in_enq_v = d; if0.out_deq__ENA = deq; if0.in_clear__ENA = clr;
  endtask

  task automatic drive1(input logic enq, input logic [W-1:0] d, input logic deq, input logic clr);
    if1.in_enq__ENA = enq; if1.in_enq_v = d; if1.out_deq__ENA = deq; if1.in_clear__ENA = clr;
  endtask

  initial begin
    logic [W-1:0] e;
    drive0(0, '0, 0, 0);
    drive1(0, '0, 0, 0);
    rst = 1'b1;

    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst0_count", 32'(if0.out_count), 0);
    check("rst0_deq_rdy", 32'(if0.out_deq__RDY), 0);
    check("rst0_first_rdy", 32'(if0.out_first__RDY), 0);
    check("rst0_enq_rdy", 32'(if0.in_enq__RDY), 1);
    check("rst0_afull", 32'(if0.out_afull), 0);
    check("rst1_count", 32'(if1.out_count), 0);
    check("rst1_enq_rdy", 32'(if1.in_enq__RDY), 1);
    rst = 1'b0;

    // Vector table: expected values are the pre-edge view for the driven inputs.
    // fill + ignored 5th enq
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 8'h00));
    tbl.push_back(mk(1, 8'h11, 0, 0, 0, 1, 0, 0, 0, 8'h00));
    tbl.push_back(mk(1, 8'h22, 0, 0, 1, 1, 1, 0, 1, 8'h11));
    tbl.push_back(mk(1, 8'h33, 0, 0, 2, 1, 1, 0, 1, 8'h11));
    tbl.push_back(mk(1, 8'h44, 0, 0, 3, 1, 1, 1, 1, 8'h11));
    tbl.push_back(mk(1, 8'h55, 0, 0, 4, 0, 1, 1, 1, 8'h11));
    tbl.push_back(mk(0, 8'h00, 0, 0, 4, 0, 1, 1, 1, 8'h11));
    // drain two, refill with wrap, drain all
    tbl.push_back(mk(0, 8'h00, 1, 0, 4, 0, 1, 1, 1, 8'h11));
    tbl.push_back(mk(0, 8'h00, 1, 0, 3, 1, 1, 1, 1, 8'h22));
    tbl.push_back(mk(1, 8'hA0, 0, 0, 2, 1, 1, 0, 1, 8'h33));
    tbl.push_back(mk(1, 8'hA1, 0, 0, 3, 1, 1, 1, 1, 8'h33));
    tbl.push_back(mk(0, 8'h00, 1, 0, 4, 0, 1, 1, 1, 8'h33));
    tbl.push_back(mk(0, 8'h00, 1, 0, 3, 1, 1, 1, 1, 8'h44));
    tbl.push_back(mk(0, 8'h00, 1, 0, 2, 1, 1, 0, 1, 8'hA0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 1, 0, 1, 8'hA1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 8'h00));
    // simultaneous enq/deq at count 2: head lags input by two entries
    tbl.push_back(mk(1, 8'h01, 0, 0, 0, 1, 0, 0, 0, 8'h00));
    tbl.push_back(mk(1, 8'h02, 0, 0, 1, 1, 1, 0, 1, 8'h01));
    for (int i = 0; i < 10; i++) begin
      e = (i == 0) ? 8'h01 : (i == 1) ? 8'h02 : 8'(8'h10 + i - 2);
      tbl.push_back(mk(1, 8'(8'h10 + i), 1, 0, 2, 1, 1, 0, 1, e));
    end
    tbl.push_back(mk(0, 8'h00, 0, 0, 2, 1, 1, 0, 1, 8'h18));
    // clear at count 3 drops the same-cycle enq
    tbl.push_back(mk(1, 8'h20, 0, 0, 2, 1, 1, 0, 1, 8'h18));
    tbl.push_back(mk(1, 8'h99, 0, 1, 3, 1, 1, 1, 1, 8'h18));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 8'h00));
    tbl.push_back(mk(1, 8'h77, 0, 0, 0, 1, 0, 0, 0, 8'h00));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 1, 1, 0, 1, 8'h77));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 1, 0, 1, 8'h77));
    // deq on empty is ignored
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, 0, 0, 8'h00));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 8'h00));

    foreach (tbl[k]) begin
      @(negedge clk);
      drive0(tbl[k].enq, tbl[k].d, tbl[k].deq, tbl[k].clr);
      #1;
      check($sformatf("v%0d_count", k), 32'(if0.out_count), 32'(tbl[k].cnt));
      check($sformatf("v%0d_enq_rdy", k), 32'(if0.in_enq__RDY), 32'(tbl[k].erdy));
      check($sformatf("v%0d_deq_rdy", k), 32'(if0.out_deq__RDY), 32'(tbl[k].drdy));
      check($sformatf("v%0d_first_rdy", k), 32'(if0.out_first__RDY), 32'(tbl[k].drdy));
      check($sformatf("v%0d_afull", k), 32'(if0.out_afull), 32'(tbl[k].af));
      if (tbl[k].chkf) check($sformatf("v%0d_first", k), 32'(if0.out_first), 32'(tbl[k].first));
    end

    // Pipelined: enq while full paired with deq
    exp_q.delete();
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); drive1(1, 8'(i), 0, 0); exp_q.push_back(8'(i));
    end
    @(negedge clk); drive1(1, 8'h05, 0, 0); #1;
    check("p1_full_count", 32'(if1.out_count), 4);
    check("p1_full_enq_rdy_nodeq", 32'(if1.in_enq__RDY), 0);
    @(negedge clk); drive1(1, 8'h05, 1, 0); #1;
    check("p1_enq_rdy_with_deq", 32'(if1.in_enq__RDY), 1);
    check("p1_first_before", 32'(if1.out_first), 32'(exp_q.pop_front()));
    exp_q.push_back(8'h05);
    @(negedge clk); drive1(0, 8'h00, 0, 0); #1;
    check("p1_count_after", 32'(if1.out_count), 4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); drive1(0, 8'h00, 1, 0); #1;
      check($sformatf("p1_drain%0d", i), 32'(if1.out_first), 32'(exp_q.pop_front()));
    end
    @(negedge clk); drive1(0, 8'h00, 0, 0); #1;
    check("p1_empty_deq_rdy", 32'(if1.out_deq__RDY), 0);
    check("p1_empty_count", 32'(if1.out_count), 0);

    // Same stimulus, non-pipelined: the enq is rejected
    exp_q.delete();
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); drive0(1, 8'(i), 0, 0); exp_q.push_back(8'(i));
    end
    @(negedge clk); drive0(1, 8'h05, 1, 0); #1;
    check("p0_enq_rdy_with_deq", 32'(if0.in_enq__RDY), 0);
    check("p0_first_before", 32'(if0.out_first), 32'(exp_q.pop_front()));
    @(negedge clk); drive0(0, 8'h00, 0, 0); #1;
    check("p0_count_after", 32'(if0.out_count), 3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive0(0, 8'h00, 1, 0); #1;
      check($sformatf("p0_drain%0d", i), 32'(if0.out_first), 32'(exp_q.pop_front()));
    end
    @(negedge clk); drive0(0, 8'h00, 0, 0); #1;
    check("p0_empty_deq_rdy", 32'(if0.out_deq__RDY), 0);

    // Asynchronous reset mid-stream, observed before the next rising edge
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive0(1, 8'(8'h60 + i), 0, 0);
    end
    @(negedge clk); drive0(0, 8'h00, 0, 0); #1;
    check("ar_count_before", 32'(if0.out_count), 3);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("ar_count", 32'(if0.out_count), 0);
    check("ar_deq_rdy", 32'(if0.out_deq__RDY), 0);
    check("ar_first_rdy", 32'(if0.out_first__RDY), 0);
    check("ar_enq_rdy", 32'(if0.in_enq__RDY), 1);
    check("ar_afull", 32'(if0.out_afull), 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    check("ar_count_after", 32'(if0.out_count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
